psqwg_sequencer: RTL and testbench

Drives the programmable square-wave generator (m/n in 100 ns units) through a small table of waveform entries.
- Each entry holds high time m, low time n and a repeat count.
- The block plays each entry for its repeat count, then advances. It plays the table once or loops.
- It re-arms the generator between entries and gates the generator's wave onto wave_out so no partial periods escape.

---
 rtl/psqwg_sequencer_if.sv | 44 ++++
 rtl/psqwg_sequencer.sv | 179 +++++++++++++++++
 tb/tb_psqwg_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/psqwg_sequencer_if.sv
// Signal bundle between the square-wave sequencer, its host and the generator.
// Compile with PSQWG_SEQ_STATUS_EN defined to add the period_cnt status output.
interface psqwg_sequencer_if #(
  parameter int unsigned M_BITS   = 4,
  parameter int unsigned N_BITS   = 4,
  parameter int unsigned IDX_BITS = 2,
  parameter int unsigned REP_BITS = 8
);
  logic                wr_en;
  logic [IDX_BITS-1:0] wr_addr;
  logic [M_BITS-1:0]   wr_m;
  logic [N_BITS-1:0]   wr_n;
  logic [REP_BITS-1:0] wr_rep;
  logic                start;
  logic                stop;
  logic                loop;
  logic                sq_wave;
  logic [M_BITS-1:0]   m;
  logic [N_BITS-1:0]   n;
  logic                gen_en;
  logic                wave_out;
  logic                busy;
  logic                done;
  logic [IDX_BITS-1:0] cur_idx;
`ifdef PSQWG_SEQ_STATUS_EN
  logic [15:0]         period_cnt;
`endif

  modport master (
    output wr_en, wr_addr, wr_m, wr_n, wr_rep, start, stop, loop, sq_wave,
    input  m, n, gen_en, wave_out, busy, done, cur_idx
`ifdef PSQWG_SEQ_STATUS_EN
    , period_cnt
`endif
  );

  modport slave (
    input  wr_en, wr_addr, wr_m, wr_n, wr_rep, start, stop, loop, sq_wave,
    output m, n, gen_en, wave_out, busy, done, cur_idx
`ifdef PSQWG_SEQ_STATUS_EN
    , period_cnt
`endif
  );
endinterface

// File: rtl/psqwg_sequencer.sv
// Plays a table of (m, n, repeat) entries through an external square-wave generator.
// Optional PSQWG_SEQ_STATUS_EN adds a saturating completed-period counter (period_cnt).
module psqwg_sequencer #(
  parameter int unsigned M_BITS   = 4,
  parameter int unsigned N_BITS   = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned IDX_BITS = 2,
  parameter int unsigned REP_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  psqwg_sequencer_if.slave bus
);
  localparam int unsigned LAST_IDX = DEPTH - 1;

  typedef struct packed {
    logic [REP_BITS-1:0] rep;
    logic [N_BITS-1:0]   n;
    logic [M_BITS-1:0]   m;
  } entry_t;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, NEXT = 2'd3} state_t;

  entry_t              table_q [DEPTH];
  state_t              state_q, state_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [M_BITS-1:0]   m_q, m_d;
  logic [N_BITS-1:0]   n_q, n_d;
  logic [REP_BITS-1:0] rep_q, rep_d;
  logic [REP_BITS-1:0] rise_cnt_q, rise_cnt_d;
  logic                sq_prev_q;
  logic                pass_valid_q, pass_valid_d;
  logic                gen_en_q, gen_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  entry_t cur_e;
  logic   rise;
  logic   term;
  logic   entry_ok;
  logic   start_ok;

  assign cur_e    = table_q[idx_q];
  assign rise     = bus.sq_wave & ~sq_prev_q;
  assign term     = (state_q == RUN) && rise && (rise_cnt_q == rep_q);
  assign entry_ok = (cur_e.m != '0) && (cur_e.n != '0) && (cur_e.rep != '0);
  assign start_ok = (state_q == IDLE) && bus.start && !bus.stop;

  // Table storage; fields are only consumed at LOAD, so writes never disturb a playing entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) table_q[i] <= '0;
    end else if (bus.wr_en) begin
      table_q[bus.wr_addr] <= {bus.wr_rep, bus.wr_n, bus.wr_m};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      m_q          <= '0;
      n_q          <= '0;
      rep_q        <= '0;
      rise_cnt_q   <= '0;
      sq_prev_q    <= 1'b0;
      pass_valid_q <= 1'b0;
      gen_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      m_q          <= m_d;
      n_q          <= n_d;
      rep_q        <= rep_d;
      rise_cnt_q   <= rise_cnt_d;
      sq_prev_q    <= bus.sq_wave;
      pass_valid_q <= pass_valid_d;
      gen_en_q     <= gen_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    m_d          = m_q;
    n_d          = n_q;
    rep_d        = rep_q;
    rise_cnt_d   = rise_cnt_q;
    pass_valid_d = pass_valid_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d      = LOAD;
          idx_d        = '0;
          pass_valid_d = 1'b0;
        end
      end
      LOAD: begin
        m_d        = cur_e.m;
        n_d        = cur_e.n;
        rep_d      = cur_e.rep;
        rise_cnt_d = '0;
        if (entry_ok) begin
          state_d      = RUN;
          pass_valid_d = 1'b1;
        end else begin
          state_d = NEXT;
        end
      end
      RUN: begin
        // rise_cnt counts periods begun; the rise after the rep-th one closes the entry
        if (term) begin
          state_d = NEXT;
        end else if (rise) begin
          rise_cnt_d = rise_cnt_q + REP_BITS'(1);
        end
      end
      NEXT: begin
        if (idx_q != IDX_BITS'(LAST_IDX)) begin
          idx_d   = idx_q + IDX_BITS'(1);
          state_d = LOAD;
        end else if (bus.loop && pass_valid_q) begin
          idx_d        = '0;
          pass_valid_d = 1'b0;
          state_d      = LOAD;
        end else begin
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && bus.stop) begin
      state_d = IDLE;
      idx_d   = '0;
      done_d  = 1'b0;
    end

    gen_en_d = (state_d == RUN);
    busy_d   = (state_d != IDLE);
  end

  assign bus.m        = m_q;
  assign bus.n        = n_q;
  assign bus.gen_en   = gen_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.cur_idx  = idx_q;
  // Gate off the terminating rise and the stop cycle so no partial period leaks out
  assign bus.wave_out = (state_q == RUN) & bus.sq_wave & ~term & ~bus.stop;

`ifdef PSQWG_SEQ_STATUS_EN
  logic [15:0] period_cnt_q, period_cnt_d;

  always_comb begin
    period_cnt_d = period_cnt_q;
    if (start_ok) begin
      period_cnt_d = '0;
    end else if ((state_q == RUN) && rise && (rise_cnt_q != '0) && (period_cnt_q != 16'hFFFF)) begin
      period_cnt_d = period_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) period_cnt_q <= '0;
    else     period_cnt_q <= period_cnt_d;
  end

  assign bus.period_cnt = period_cnt_q;
`endif
endmodule

// File: tb/tb_psqwg_sequencer.sv
// Directed bench for psqwg_sequencer with a behavioural square-wave generator (5 clocks per m/n unit).
// Checks period_cnt as well when PSQWG_SEQ_STATUS_EN is defined.
module tb_psqwg_sequencer;
  logic clk;
  logic rst;

  psqwg_sequencer_if bus ();

  psqwg_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Generator model: held in S0 while disabled, high m*5 clocks then low n*5 clocks
  int gcnt;
  int hi_len;
  int per_len;
  assign hi_len  = int'(bus.m) * 5;
  assign per_len = (int'(bus.m) + int'(bus.n)) * 5;
  always @(posedge clk or posedge rst) begin
    if (rst)              gcnt <= 0;
    else if (!bus.gen_en) gcnt <= 0;
    else                  gcnt <= (gcnt >= per_len - 1) ? 0 : gcnt + 1;
  end
  assign bus.sq_wave = bus.gen_en && (gcnt < hi_len);

  int n_cmp = 0;
  int n_err = 0;

  int rises[$];
  int ridx[$];
  int highs[$];
  int gaps[$];
  int hl, gap, done_cnt, cyc;
  bit pw, gen_seen;
  logic [3:0] run_mask;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clr_mon();
    rises.delete(); ridx.delete(); highs.delete(); gaps.delete();
    hl = 0; gap = 0; done_cnt = 0; gen_seen = 1'b0; run_mask = '0;
    pw = bus.wave_out;
  endtask

  task automatic sample();
    if (bus.wave_out && !pw) begin
      rises.push_back(cyc);
      ridx.push_back(int'(bus.cur_idx));
      hl = 1;
    end else if (bus.wave_out) begin
      hl++;
    end else if (pw) begin
      highs.push_back(hl);
    end
    pw = bus.wave_out;
    if (bus.gen_en) gen_seen = 1'b1;
    if (bus.done) done_cnt++;
    if (bus.busy && bus.gen_en) run_mask[bus.cur_idx] = 1'b1;
    if (!bus.busy) gap = 0;
    else if (!bus.gen_en) gap++;
    else if (gap != 0) begin
      gaps.push_back(gap);
      gap = 0;
    end
  endtask

  task automatic step(input int k = 1);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      cyc++;
      sample();
    end
  endtask

  task automatic wr(input int a, input int mm, input int nn, input int rr);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'(a);
    bus.wr_m    = 4'(mm);
    bus.wr_n    = 4'(nn);
    bus.wr_rep  = 8'(rr);
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_cnt == 0; k++) step();
  endtask

  initial begin
    int n;
    cyc = 0;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_m = '0; bus.wr_n = '0; bus.wr_rep = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
    #15;
    check("rst_m", bus.m, 0);
    check("rst_n", bus.n, 0);
    check("rst_gen_en", bus.gen_en, 0);
    check("rst_wave", bus.wave_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_idx", bus.cur_idx, 0);
`ifdef PSQWG_SEQ_STATUS_EN
    check("rst_pcnt", bus.period_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    clr_mon();

    // start together with stop is refused
    bus.start = 1'b1; bus.stop = 1'b1;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    check("t0_busy", bus.busy, 0);

    // 1: single entry, three periods
    wr(0, 1, 1, 3); wr(1, 0, 0, 0); wr(2, 0, 0, 0); wr(3, 0, 0, 0);
    bus.loop = 1'b0;
    clr_mon();
    pulse_start();
    check("t1_lat1_gen", bus.gen_en, 0);
    check("t1_busy", bus.busy, 1);
    step();
    check("t1_lat2_gen", bus.gen_en, 1);
    wait_done(200);
    step(3);
    check("t1_pulses", highs.size(), 3);
    check("t1_hi0", at(highs, 0), 5);
    check("t1_hi2", at(highs, 2), 5);
    check("t1_per01", at(rises, 1) - at(rises, 0), 10);
    check("t1_per12", at(rises, 2) - at(rises, 1), 10);
    check("t1_done", done_cnt, 1);
    check("t1_busy_end", bus.busy, 0);
    check("t1_gen_end", bus.gen_en, 0);
`ifdef PSQWG_SEQ_STATUS_EN
    check("t1_pcnt", bus.period_cnt, 3);
`endif

    // 2: two entries, plus a start while busy that must be ignored
    wr(0, 1, 1, 2); wr(1, 2, 3, 1);
    clr_mon();
    pulse_start();
    step();
    pulse_start();
    wait_done(300);
    step(3);
    check("t2_pulses", highs.size(), 3);
    check("t2_hi1", at(highs, 1), 5);
    check("t2_hi2", at(highs, 2), 10);
    check("t2_idx_first", at(ridx, 0), 0);
    check("t2_idx_last", at(ridx, 2), 1);
    check("t2_ngaps", gaps.size(), 2);
    check("t2_gap_between", at(gaps, 1), 2);
    check("t2_done", done_cnt, 1);

    // 3: looping single entry, stopped during the third pulse
    wr(0, 1, 1, 1); wr(1, 0, 0, 0);
    bus.loop = 1'b1;
    clr_mon();
    pulse_start();
    for (int k = 0; k < 300 && rises.size() < 3; k++) step();
    step(2);
    check("t3_pre_wave", bus.wave_out, 1);
    bus.stop = 1'b1;
    #1;
    check("t3_stop_wave", bus.wave_out, 0);
    step();
    bus.stop = 1'b0;
    check("t3_gen_en", bus.gen_en, 0);
    check("t3_busy", bus.busy, 0);
    step(3);
    check("t3_no_done", done_cnt, 0);
`ifdef PSQWG_SEQ_STATUS_EN
    check("t3_pcnt", bus.period_cnt, 2);
`endif

    // 4: invalid entries 1 and 3 are skipped
    wr(0, 1, 1, 1); wr(1, 0, 1, 1); wr(2, 1, 1, 1); wr(3, 0, 0, 0);
    bus.loop = 1'b0;
    clr_mon();
    pulse_start();
    wait_done(200);
    step(2);
    check("t4_run_mask", run_mask, 4'b0101);
    check("t4_pulses", highs.size(), 2);
    check("t4_done", done_cnt, 1);

    // 5: empty table terminates even with loop set
    wr(0, 0, 0, 0); wr(2, 1, 0, 5);
    bus.loop = 1'b1;
    clr_mon();
    pulse_start();
    n = 1;
    while (done_cnt == 0 && n < 40) begin
      step();
      n++;
    end
    check("t5_done_lat", n, 9);
    step(3);
    check("t5_gen_seen", gen_seen, 0);
    check("t5_done", done_cnt, 1);
    check("t5_busy", bus.busy, 0);

    // 6: async reset in the middle of a high phase
    wr(0, 1, 1, 3);
    bus.loop = 1'b0;
    clr_mon();
    pulse_start();
    for (int k = 0; k < 50 && rises.size() < 1; k++) step();
    step();
    check("t6_pre_wave", bus.wave_out, 1);
    #3 rst = 1'b1;
    #1;
    check("t6_gen_en", bus.gen_en, 0);
    check("t6_wave", bus.wave_out, 0);
    check("t6_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    clr_mon();
    pulse_start();
    wait_done(50);
    step(2);
    check("t6_pulses", rises.size(), 0);
    check("t6_gen_seen", gen_seen, 0);
    check("t6_done", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
